// File: rtl/ifu_pkg.sv
// Shared fetch-unit definitions: widths, reset PC and FSM state encoding.
package ifu_pkg;

  localparam int unsigned CPU_WIDTH  = 64;
  localparam int unsigned INS_WIDTH  = 32;
  localparam logic [63:0] IFU_RST_PC = 64'h8000_0000;

  typedef enum logic [1:0] {
    S_REQ,
    S_WAIT,
    S_HOLD,
    S_DRAIN
  } ifu_state_t;

endpackage

// File: rtl/ifu.sv
// Instruction fetch unit: one outstanding word fetch, a single-entry hold
// register towards decode, and redirects that squash wrong-path fetches.
module ifu
  import ifu_pkg::*;
#(
  parameter int unsigned     PC_W   = CPU_WIDTH,
  parameter int unsigned     INS_W  = INS_WIDTH,
  parameter logic [PC_W-1:0] RST_PC = PC_W'(IFU_RST_PC)
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  output logic             o_imem_req_valid,
  input  logic             i_imem_req_ready,
  output logic [PC_W-1:0]  o_imem_addr,
  input  logic             i_imem_rsp_valid,
  input  logic [INS_W-1:0] i_imem_rdata,
  output logic             o_ins_valid,
  input  logic             i_ins_ready,
  output logic [INS_W-1:0] o_ins,
  output logic [PC_W-1:0]  o_pc,
  input  logic             i_redirect,
  input  logic [PC_W-1:0]  i_redirect_pc,
  output logic             o_misalign
);

  ifu_state_t       state_q, state_d;
  logic [PC_W-1:0]  pc_q, pc_d;
  logic [INS_W-1:0] ins_q, ins_d;
  logic [PC_W-1:0]  ipc_q, ipc_d;
  logic             mis_q, mis_d;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q <= S_REQ;
      pc_q    <= RST_PC;
      ins_q   <= '0;
      ipc_q   <= '0;
      mis_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ins_q   <= ins_d;
      ipc_q   <= ipc_d;
      mis_q   <= mis_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ins_d   = ins_q;
    ipc_d   = ipc_q;
    mis_d   = mis_q;

    unique case (state_q)
      S_REQ: begin
        if (!i_redirect && i_imem_req_ready) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (i_redirect) begin
          state_d = i_imem_rsp_valid ? S_REQ : S_DRAIN;
        end else if (i_imem_rsp_valid) begin
          ins_d   = i_imem_rdata;
          ipc_d   = pc_q;
          pc_d    = pc_q + PC_W'(4);
          state_d = S_HOLD;
        end
      end
      S_HOLD: begin
        if (i_redirect || i_ins_ready) state_d = S_REQ;
      end
      S_DRAIN: begin
        if (i_imem_rsp_valid) state_d = S_REQ;
      end
      default: state_d = S_REQ;
    endcase

    // Redirect overrides any pc update made by the state logic above.
    if (i_redirect) begin
      pc_d = {i_redirect_pc[PC_W-1:2], 2'b00};
      if (i_redirect_pc[1:0] != 2'b00) mis_d = 1'b1;
    end
  end

  assign o_imem_req_valid = i_rst_n && (state_q == S_REQ)  && !i_redirect;
  assign o_ins_valid      = i_rst_n && (state_q == S_HOLD) && !i_redirect;
  assign o_imem_addr      = pc_q;
  assign o_ins            = ins_q;
  assign o_pc             = ipc_q;
  assign o_misalign       = mis_q;

endmodule

// File: tb/tb_ifu.sv
// Self-checking bench for ifu: directed vector table, hand-written corner
// sequences and a randomized memory/decode/redirect run against a model.
module tb_ifu;

  localparam logic [63:0] RSTPC = 64'h8000_0000;

  logic        i_clk = 1'b0;
  logic        i_rst_n;
  logic        o_imem_req_valid;
  logic        i_imem_req_ready;
  logic [63:0] o_imem_addr;
  logic        i_imem_rsp_valid;
  logic [31:0] i_imem_rdata;
  logic        o_ins_valid;
  logic        i_ins_ready;
  logic [31:0] o_ins;
  logic [63:0] o_pc;
  logic        i_redirect;
  logic [63:0] i_redirect_pc;
  logic        o_misalign;

  int checks = 0;
  int errors = 0;

  ifu #(.PC_W(64), .INS_W(32), .RST_PC(RSTPC)) dut (
    .i_clk            (i_clk),
    .i_rst_n          (i_rst_n),
    .o_imem_req_valid (o_imem_req_valid),
    .i_imem_req_ready (i_imem_req_ready),
    .o_imem_addr      (o_imem_addr),
    .i_imem_rsp_valid (i_imem_rsp_valid),
    .i_imem_rdata     (i_imem_rdata),
    .o_ins_valid      (o_ins_valid),
    .i_ins_ready      (i_ins_ready),
    .o_ins            (o_ins),
    .o_pc             (o_pc),
    .i_redirect       (i_redirect),
    .i_redirect_pc    (i_redirect_pc),
    .o_misalign       (o_misalign)
  );

  always #5 i_clk = ~i_clk;

  // Transaction-level reference: is a fetch in flight, is it wrong-path,
  // is an instruction sitting with decode, and what is the next fetch PC.
  logic        m_out, m_disc, m_held, m_mis;
  logic [63:0] m_npc, m_hpc;
  logic [31:0] m_hins;
  logic        m_accept;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Inputs are already driven; check outputs mid-cycle, then advance the model at the edge.
  task automatic step(input bit chk);
    logic exp_reqv, exp_insv;
    logic n_out, n_disc, n_held;
    #1;
    exp_reqv = i_rst_n && !m_out && !m_held && !i_redirect;
    exp_insv = i_rst_n && m_held && !i_redirect;
    if (chk) begin
      check("req_valid", 64'(o_imem_req_valid), 64'(exp_reqv));
      check("ins_valid", 64'(o_ins_valid), 64'(exp_insv));
      check("imem_addr", o_imem_addr, m_npc);
      check("ins", 64'(o_ins), 64'(m_hins));
      check("pc", o_pc, m_hpc);
      check("misalign", 64'(o_misalign), 64'(m_mis));
    end
    @(posedge i_clk);
    m_accept = exp_reqv && i_imem_req_ready;
    if (!i_rst_n) begin
      m_out = 0; m_disc = 0; m_held = 0; m_mis = 0;
      m_npc = RSTPC; m_hpc = '0; m_hins = '0;
    end else begin
      n_out = m_out; n_disc = m_disc; n_held = m_held;
      if (m_out && i_imem_rsp_valid) begin
        n_out = 0; n_disc = 0;
        if (!m_disc && !i_redirect) begin
          n_held = 1; m_hins = i_imem_rdata; m_hpc = m_npc; m_npc = m_npc + 64'd4;
        end
      end else if (m_out && i_redirect) begin
        n_disc = 1;
      end
      if (m_held && (i_redirect || i_ins_ready)) n_held = 0;
      if (m_accept) begin n_out = 1; n_disc = 0; end
      if (i_redirect) begin
        m_npc = {i_redirect_pc[63:2], 2'b00};
        if (i_redirect_pc[1:0] != 2'b00) m_mis = 1;
      end
      m_out = n_out; m_disc = n_disc; m_held = n_held;
    end
    @(negedge i_clk);
  endtask

  task automatic drive(input logic rst, input logic rr, input logic rv, input logic [31:0] rd,
                       input logic ir, input logic redir, input logic [63:0] rpc);
    i_rst_n = rst; i_imem_req_ready = rr; i_imem_rsp_valid = rv; i_imem_rdata = rd;
    i_ins_ready = ir; i_redirect = redir; i_redirect_pc = rpc;
  endtask

  typedef struct {
    logic        rr, rv, ir, redir;
    logic [63:0] rpc;
    logic        e_reqv, e_insv;
    logic [63:0] e_addr, e_pc;
  } vec_t;

  vec_t vt[16];
  int unsigned cnt;

  initial begin
    m_out = 0; m_disc = 0; m_held = 0; m_mis = 0;
    m_npc = '0; m_hpc = '0; m_hins = '0; m_accept = 0;

    //         rr  rv  ir  rd  rpc                    reqv insv addr                  pc
    vt[0]  = '{1, 0, 1, 0, 64'h0,                    1, 0, 64'h8000_0000, 64'h0};
    vt[1]  = '{1, 1, 1, 0, 64'h0,                    0, 0, 64'h8000_0000, 64'h0};
    vt[2]  = '{0, 0, 1, 0, 64'h0,                    0, 1, 64'h8000_0004, 64'h8000_0000};
    vt[3]  = '{1, 0, 1, 0, 64'h0,                    1, 0, 64'h8000_0004, 64'h8000_0000};
    vt[4]  = '{1, 1, 1, 0, 64'h0,                    0, 0, 64'h8000_0004, 64'h8000_0000};
    vt[5]  = '{1, 0, 1, 1, 64'h8000_0200,            0, 0, 64'h8000_0008, 64'h8000_0004};
    vt[6]  = '{1, 0, 1, 0, 64'h0,                    1, 0, 64'h8000_0200, 64'h8000_0004};
    vt[7]  = '{1, 0, 1, 1, 64'h8000_0100,            0, 0, 64'h8000_0200, 64'h8000_0004};
    vt[8]  = '{1, 0, 1, 0, 64'h0,                    0, 0, 64'h8000_0100, 64'h8000_0004};
    vt[9]  = '{1, 0, 1, 0, 64'h0,                    0, 0, 64'h8000_0100, 64'h8000_0004};
    vt[10] = '{1, 1, 1, 0, 64'h0,                    0, 0, 64'h8000_0100, 64'h8000_0004};
    vt[11] = '{0, 0, 1, 0, 64'h0,                    1, 0, 64'h8000_0100, 64'h8000_0004};
    vt[12] = '{1, 0, 1, 0, 64'h0,                    1, 0, 64'h8000_0100, 64'h8000_0004};
    vt[13] = '{1, 1, 0, 0, 64'h0,                    0, 0, 64'h8000_0100, 64'h8000_0004};
    vt[14] = '{1, 0, 0, 0, 64'h0,                    0, 1, 64'h8000_0104, 64'h8000_0100};
    vt[15] = '{1, 0, 1, 0, 64'h0,                    0, 1, 64'h8000_0104, 64'h8000_0100};

    drive(0, 0, 0, '0, 0, 0, '0);
    step(0);
    step(1);

    for (int i = 0; i < 16; i++) begin
      drive(1, vt[i].rr, vt[i].rv, 32'h0000_0013, vt[i].ir, vt[i].redir, vt[i].rpc);
      #1;
      check($sformatf("vec%0d_reqv", i), 64'(o_imem_req_valid), 64'(vt[i].e_reqv));
      check($sformatf("vec%0d_insv", i), 64'(o_ins_valid), 64'(vt[i].e_insv));
      check($sformatf("vec%0d_addr", i), o_imem_addr, vt[i].e_addr);
      check($sformatf("vec%0d_pc", i), o_pc, vt[i].e_pc);
      step(1);
    end

    // Decode stalls for five cycles on a held instruction.
    drive(1, 1, 0, '0, 0, 0, '0);            step(1);
    drive(1, 0, 1, 32'hDEAD_BEEF, 0, 0, '0); step(1);
    for (int i = 0; i < 5; i++) begin
      drive(1, 1, 0, 32'h1234_5678, 0, 0, '0);
      #1;
      check("stall_ins", 64'(o_ins), 64'h0000_0000_DEAD_BEEF);
      check("stall_pc", o_pc, 64'h8000_0104);
      check("stall_valid", 64'(o_ins_valid), 64'd1);
      check("stall_noreq", 64'(o_imem_req_valid), 64'd0);
      step(1);
    end
    drive(1, 0, 0, '0, 1, 0, '0); step(1);

    // Misaligned redirect, then the memory back-pressures for four cycles.
    drive(1, 0, 0, '0, 1, 1, 64'h8000_0302); step(1);
    for (int i = 0; i < 4; i++) begin
      drive(1, 0, 0, '0, 1, 0, '0);
      #1;
      check("bp_reqv", 64'(o_imem_req_valid), 64'd1);
      check("bp_addr", o_imem_addr, 64'h8000_0300);
      check("bp_mis", 64'(o_misalign), 64'd1);
      step(1);
    end
    drive(1, 1, 0, '0, 1, 0, '0);            step(1);
    drive(1, 0, 1, 32'h0000_0013, 1, 0, '0); step(1);
    drive(1, 0, 0, '0, 1, 0, '0);            step(1);

    // Reset while a fetch is outstanding.
    drive(1, 1, 0, '0, 1, 0, '0); step(1);
    drive(0, 0, 0, '0, 1, 0, '0); step(1);
    drive(1, 0, 0, '0, 1, 0, '0);
    #1;
    check("rst_insv", 64'(o_ins_valid), 64'd0);
    check("rst_addr", o_imem_addr, RSTPC);
    check("rst_mis", 64'(o_misalign), 64'd0);
    check("rst_reqv", 64'(o_imem_req_valid), 64'd1);
    step(1);

    // Randomized memory latency, back-pressure, redirects and resets.
    cnt = 0;
    for (int c = 0; c < 4000; c++) begin
      logic rv;
      logic [63:0] rpc;
      rv = m_out && (cnt == 0);
      rpc = {32'h8000_0000 | 32'($urandom_range(0, 32'hFFFF)), $urandom};
      if ($urandom_range(0, 7) != 0) rpc[1:0] = 2'b00;
      drive(($urandom_range(0, 299) != 0), ($urandom_range(0, 2) != 0), rv, $urandom,
            ($urandom_range(0, 2) != 0), ($urandom_range(0, 9) == 0), rpc);
      step(1);
      if (m_accept) cnt = $urandom_range(0, 3);
      else if (cnt != 0) cnt--;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
